// File: rtl/ram_dma.sv
// Block-transfer initiator for the NBBPU data RAM: copies a word range
// (read/write pairs) or fills a range with a constant, one word at a time.
module ram_dma #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [ADDRESS_WIDTH-1:0] src_address,
    input  logic [ADDRESS_WIDTH-1:0] dst_address,
    input  logic [ADDRESS_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0]    fill_data,
    output logic                     read_enable,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0]    write_data,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FILL  = 2'd3
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] src_q, src_d;
    logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
    logic [ADDRESS_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0]    fill_q, fill_d;
    // The word index and the written-word count always advance together,
    // so a single register serves as both.
    logic [ADDRESS_WIDTH-1:0] count_q, count_d;
    logic                     done_q, done_d;
    logic [ADDRESS_WIDTH-1:0] count_inc;

    assign count_inc = count_q + ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        fill_d       = fill_q;
        count_d      = count_q;
        done_d       = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        address      = '0;
        write_data   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_address;
                    dst_d   = dst_address;
                    len_d   = length;
                    fill_d  = fill_data;
                    count_d = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = mode ? FILL : READ;
                    end
                end
            end
            READ: begin
                read_enable = 1'b1;
                address     = src_q + count_q;
                state_d     = WRITE;
            end
            WRITE: begin
                // RAM output is registered, so read_data now holds the word
                // fetched in the preceding READ cycle.
                write_enable = 1'b1;
                address      = dst_q + count_q;
                write_data   = read_data;
                count_d      = count_inc;
                if (count_inc == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = READ;
                end
            end
            FILL: begin
                write_enable = 1'b1;
                address      = dst_q + count_q;
                write_data   = fill_q;
                count_d      = count_inc;
                if (count_inc == len_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign count = count_q;

endmodule
